// File: rtl/mlp_stream_sequencer.sv
// mlp_stream_sequencer
// Host-side sequencer for the MLP accelerator. For each layer pass it reads
// ifmap, weight and bias words from a unified buffer and streams them to the
// accelerator, then captures the returned ofmap words back into the buffer.
// Runs 1..MAX_PASS passes per start; in chain mode the ofmap of pass p-1 is
// re-fed as the bias stream of pass p.
//
// Optional feature macro: LOADER_PERF_EN (busy-cycle counter on perf_cycles;
// when undefined perf_cycles is tied to 0).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               1-cycle run request, accepted only when idle
//   num_pass            passes to run (1..MAX_PASS), sampled at start
//   chain_mode          bias of pass p>0 comes from ofmap of pass p-1
//   *_base              buffer region bases, sampled at start
//   rd_en/rd_addr       buffer read port; rd_data valid one cycle after rd_en
//   wr_en/wr_addr/wr_data  buffer write port for ofmap words
//   acc_ready           1-cycle pulse opening an accelerator pass
//   acc_data            operand stream to the accelerator (0 when idle)
//   acc_valid/acc_ofmap ofmap words returned by the accelerator
//   busy, done, error   run status; error is sticky until the next start
//   perf_cycles         busy-cycle count of the last run
module mlp_stream_sequencer #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 16,
    parameter int IFMAP_WORDS  = 16,
    parameter int WEIGHT_WORDS = 1024,
    parameter int BIAS_WORDS   = 64,
    parameter int OFMAP_WORDS  = 64,
    parameter int MAX_PASS     = 4,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [$clog2(MAX_PASS):0] num_pass,
    input  logic                      chain_mode,
    input  logic [ADDR_W-1:0]         ifmap_base,
    input  logic [ADDR_W-1:0]         weight_base,
    input  logic [ADDR_W-1:0]         bias_base,
    input  logic [ADDR_W-1:0]         ofmap_base,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [DATA_W-1:0]         rd_data,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      acc_ready,
    output logic [DATA_W-1:0]         acc_data,
    input  logic                      acc_valid,
    input  logic [DATA_W-1:0]         acc_ofmap,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [31:0]               perf_cycles
);

    localparam int NP_W = $clog2(MAX_PASS) + 1;
    localparam int L    = IFMAP_WORDS + WEIGHT_WORDS + BIAS_WORDS;
    localparam int RC_W = $clog2(L + 1);
    localparam int OC_W = $clog2(OFMAP_WORDS + 1);
    localparam int TC_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_QUIESCE, S_KICK, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [RC_W-1:0]   rd_cnt;
    logic [OC_W-1:0]   ofmap_cnt;
    logic [TC_W-1:0]   tmo_cnt;
    logic [NP_W-1:0]   pass_idx;
    logic              rd_vld_p1;
    logic              set_error;
    logic              start_acc;
    logic              capture;
    logic              pass_done;
    logic              last_pass;

    logic [NP_W-1:0]   num_pass_q;
    logic              chain_q;
    logic [ADDR_W-1:0] ifmap_base_q, weight_base_q, bias_base_q, ofmap_base_q;

    logic [ADDR_W-1:0] pa, rd_idx, wr_idx;

    assign start_acc = start && (state == S_IDLE);
    assign capture   = (state == S_KICK) || (state == S_STREAM) || (state == S_DRAIN);
    assign pass_done = (ofmap_cnt == OC_W'(OFMAP_WORDS));
    assign last_pass = (NP_W'(pass_idx + 1'b1) == num_pass_q);

    // Configuration is captured once per accepted start.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            num_pass_q    <= num_pass;
            chain_q       <= chain_mode;
            ifmap_base_q  <= ifmap_base;
            weight_base_q <= weight_base;
            bias_base_q   <= bias_base;
            ofmap_base_q  <= ofmap_base;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_cnt    <= '0;
            ofmap_cnt <= '0;
            tmo_cnt   <= '0;
            pass_idx  <= '0;
            rd_vld_p1 <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            // Read index runs only while reading; word 0 is issued in KICK.
            rd_cnt    <= rd_en ? rd_cnt + 1'b1 : '0;
            // Stage boundary: buffer read -> accelerator stream.
            rd_vld_p1 <= rd_en;
            if (wr_en)
                ofmap_cnt <= ofmap_cnt + 1'b1;
            else if (state == S_IDLE || state == S_QUIESCE)
                ofmap_cnt <= '0;
            tmo_cnt <= (state == S_DRAIN && !acc_valid) ? tmo_cnt + 1'b1 : '0;
            if (state == S_IDLE)
                pass_idx <= '0;
            else if (state == S_DRAIN && pass_done && !last_pass)
                pass_idx <= pass_idx + 1'b1;
            if (start_acc)
                error <= 1'b0;
            else if (set_error)
                error <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        set_error = 1'b0;
        case (state)
            S_IDLE:    if (start) state_nxt = S_CHECK;
            S_CHECK: begin
                if (num_pass_q == '0 || num_pass_q > NP_W'(MAX_PASS) ||
                    (chain_q && BIAS_WORDS != OFMAP_WORDS)) begin
                    set_error = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_QUIESCE;
                end
            end
            // Never open a pass while the accelerator is still emitting words.
            S_QUIESCE: if (!acc_valid) state_nxt = S_KICK;
            S_KICK:    state_nxt = S_STREAM;
            S_STREAM:  if (rd_cnt == RC_W'(L - 1)) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (pass_done) begin
                    state_nxt = last_pass ? S_DONE : S_QUIESCE;
                end else if (!acc_valid && tmo_cnt == TC_W'(TIMEOUT_CYC - 1)) begin
                    set_error = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    assign rd_en     = (state == S_KICK) || (state == S_STREAM);
    assign acc_ready = (state == S_KICK);
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign acc_data  = rd_vld_p1 ? rd_data : '0;

    // Words past OFMAP_WORDS in a pass are dropped.
    assign wr_en   = capture && acc_valid && (ofmap_cnt < OC_W'(OFMAP_WORDS));
    assign wr_data = wr_en ? acc_ofmap : '0;

    always_comb begin
        pa      = ADDR_W'(pass_idx);
        rd_idx  = ADDR_W'(rd_cnt);
        wr_idx  = ADDR_W'(ofmap_cnt);
        rd_addr = '0;
        wr_addr = '0;
        if (rd_en) begin
            if (rd_cnt < RC_W'(IFMAP_WORDS))
                rd_addr = ifmap_base_q + pa * ADDR_W'(IFMAP_WORDS) + rd_idx;
            else if (rd_cnt < RC_W'(IFMAP_WORDS + WEIGHT_WORDS))
                rd_addr = weight_base_q + pa * ADDR_W'(WEIGHT_WORDS) + rd_idx
                          - ADDR_W'(IFMAP_WORDS);
            else if (chain_q && pass_idx != '0)
                // Chain mode: bias comes from the previous pass's ofmap region.
                rd_addr = ofmap_base_q + (pa - 1'b1) * ADDR_W'(OFMAP_WORDS) + rd_idx
                          - ADDR_W'(IFMAP_WORDS + WEIGHT_WORDS);
            else
                rd_addr = bias_base_q + pa * ADDR_W'(BIAS_WORDS) + rd_idx
                          - ADDR_W'(IFMAP_WORDS + WEIGHT_WORDS);
        end
        if (wr_en)
            wr_addr = ofmap_base_q + pa * ADDR_W'(OFMAP_WORDS) + wr_idx;
    end

`ifdef LOADER_PERF_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk) begin
        if (rst)
            perf_q <= '0;
        else if (start_acc)
            perf_q <= '0;
        else if (busy)
            perf_q <= perf_q + 1'b1;
    end
    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_mlp_stream_sequencer.sv
// Bench for mlp_stream_sequencer: buffer memory, accelerator model, reference
// address/data model and a per-cycle compare process, driven by directed runs.
module tb_mlp_stream_sequencer;

    localparam int IFW = 16, WW = 1024, BW = 64, OW = 64, MAXP = 4, TMO = 4096;
    localparam int L = IFW + WW + BW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  num_pass = '0;
    logic        chain_mode = 1'b0;
    logic [15:0] ifmap_base = '0, weight_base = '0, bias_base = '0, ofmap_base = '0;
    logic        rd_en, wr_en, acc_ready, busy, done, error;
    logic [15:0] rd_addr, wr_addr;
    logic [31:0] rd_data, wr_data, acc_data, perf_cycles;
    logic [31:0] acc_ofmap = '0;
    logic        acc_valid;
    logic        mdl_valid = 1'b0, hold_valid = 1'b0;
    assign acc_valid = mdl_valid | hold_valid;

    mlp_stream_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .num_pass(num_pass), .chain_mode(chain_mode),
        .ifmap_base(ifmap_base), .weight_base(weight_base), .bias_base(bias_base),
        .ofmap_base(ofmap_base), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .acc_ready(acc_ready),
        .acc_data(acc_data), .acc_valid(acc_valid), .acc_ofmap(acc_ofmap), .busy(busy),
        .done(done), .error(error), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Buffer memory seen by the DUT, and the reference image of it.
    logic [31:0] mem  [0:65535];
    logic [31:0] gmem [0:65535];
    function automatic logic [31:0] pat(input int a);
        return 32'(a) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Expected read stream of a run, built from the address rules.
    typedef struct packed { logic [15:0] addr; logic first; } rd_t;
    rd_t rdq[$];

    task automatic build_reads(input int np, input int chain, input int ib, input int wb,
                               input int bb, input int ob);
        rd_t r;
        rdq.delete();
        if (np < 1 || np > MAXP) return;
        for (int p = 0; p < np; p++)
            for (int i = 0; i < L; i++) begin
                if (i < IFW)           r.addr = 16'(ib + p * IFW + i);
                else if (i < IFW + WW) r.addr = 16'(wb + p * WW + i - IFW);
                else if (chain != 0 && p > 0)
                    r.addr = 16'(ob + (p - 1) * OW + i - IFW - WW);
                else                   r.addr = 16'(bb + p * BW + i - IFW - WW);
                r.first = (i == 0);
                rdq.push_back(r);
            end
    endtask

    // Accelerator model: consumes L stream words after acc_ready, then returns
    // acc_words ofmap words back-to-back.
    int          acc_words = 64;
    int          run_pass = 0;
    int          cur_ob = 0;
    int          last_valid_cyc = 0;
    int          kick_cyc = 0;
    logic        exp_wr = 1'b0;
    logic [15:0] exp_waddr = '0;
    logic [31:0] exp_wdata = '0;

    initial begin : accel
        int p;
        logic [31:0] sum;
        bit aborted;
        forever begin
            @(negedge clk);
            if (acc_ready && !rst) begin
                p = run_pass;
                run_pass++;
                kick_cyc = cyc;
                sum = 32'h1;
                aborted = 1'b0;
                for (int i = 0; i < L; i++) begin
                    @(negedge clk);
                    if (rst) begin aborted = 1'b1; break; end
                    sum = {sum[30:0], sum[31]} ^ acc_data;
                end
                if (!aborted)
                    for (int k = 0; k < acc_words; k++) begin
                        @(posedge clk); #1;
                        mdl_valid = 1'b1;
                        acc_ofmap = sum + 32'(k) * 32'h0101_0101 + 32'(p);
                        exp_wr    = (k < OW);
                        exp_waddr = 16'(cur_ob + p * OW + k);
                        exp_wdata = acc_ofmap;
                        last_valid_cyc = cyc;
                    end
                @(posedge clk); #1;
                mdl_valid = 1'b0;
                exp_wr = 1'b0;
                acc_ofmap = '0;
            end
        end
    end

    // Per-cycle compare against the reference model.
    bit          chk_en = 1'b0;
    int          stream_left = 0;
    bit          prev_rd = 1'b0;
    logic [15:0] prev_addr = '0;
    int          n_rd = 0, n_wr = 0, n_ready = 0, rd_run_idx = 0;
    logic [15:0] bias1_addr = '0;
    logic [15:0] wr_log[$];

    always @(negedge clk) begin
        rd_t r;
        if (chk_en) begin
            chk("acc_data", acc_data, prev_rd ? gmem[prev_addr] : 32'h0);
            if (acc_ready) n_ready++;
            if (rd_en) begin
                chk("rd_pending", 64'(rdq.size() != 0), 1);
                prev_rd = 1'b0;
                if (rdq.size() != 0) begin
                    r = rdq.pop_front();
                    chk("rd_addr", rd_addr, r.addr);
                    chk("acc_ready", acc_ready, r.first);
                    if (r.first) stream_left = L - 1;
                    else begin
                        chk("rd_in_stream", 64'(stream_left > 0), 1);
                        if (stream_left > 0) stream_left--;
                    end
                    if (rd_run_idx == L + IFW + WW) bias1_addr = rd_addr;
                    rd_run_idx++;
                    n_rd++;
                    prev_rd = 1'b1;
                    prev_addr = r.addr;
                end
            end else begin
                chk("acc_ready_idle", acc_ready, 0);
                chk("rd_gap", stream_left, 0);
                stream_left = 0;
                prev_rd = 1'b0;
            end
            chk("wr_en", wr_en, exp_wr);
            if (exp_wr && wr_en) begin
                chk("wr_addr", wr_addr, exp_waddr);
                chk("wr_data", wr_data, exp_wdata);
                gmem[exp_waddr] = exp_wdata;
                n_wr++;
                wr_log.push_back(wr_addr);
            end
`ifndef LOADER_PERF_EN
            chk("perf_off", perf_cycles, 0);
`endif
            if (rst) begin
                rdq.delete();
                stream_left = 0;
                prev_rd = 1'b0;
            end
        end
    end

    // One run: start pulse, then wait (bounded) for done.
    task automatic run(input int np, input int chain, input int ib, input int wb,
                       input int bb, input int ob, input int words, input bit start_at_done,
                       output int dcyc, output int dabs, output int bc, output logic err);
        int k;
        num_pass = 3'(np); chain_mode = chain[0];
        ifmap_base = 16'(ib); weight_base = 16'(wb); bias_base = 16'(bb); ofmap_base = 16'(ob);
        build_reads(np, chain, ib, wb, bb, ob);
        run_pass = 0; cur_ob = ob; acc_words = words;
        n_rd = 0; n_wr = 0; n_ready = 0; rd_run_idx = 0; wr_log.delete(); bias1_addr = '0;
        dcyc = -1; dabs = 0; bc = 0; err = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        k = 1;
        while (k <= 20000) begin
            @(negedge clk);
            if (k == 1) begin
                chk("busy_after_start", busy, 1);
                chk("error_cleared", error, 0);
            end
            if (done) begin
                dcyc = k; dabs = cyc; err = error;
                break;
            end
            if (busy) bc++;
            @(posedge clk);
            k++;
        end
        if (dcyc < 0) chk("done_wait", 0, 1);
        if (start_at_done) start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("done_single", done, 0);
        chk("busy_after_done", busy, 0);
        chk("rd_drained", rdq.size(), 0);
    endtask

    int          dc, da, bcnt, rel_cyc;
    logic        e;

    initial begin : main
        for (int a = 0; a < 65536; a++) begin mem[a] = pat(a); gmem[a] = pat(a); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", rd_en, 0);     chk("rst_wr_en", wr_en, 0);
        chk("rst_acc_ready", acc_ready, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);       chk("rst_error", error, 0);
        chk("rst_perf", perf_cycles, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);

        // Single pass, bases 0/16/1040/1104.
        run(1, 0, 0, 16, 1040, 1104, 64, 0, dc, da, bcnt, e);
        chk("t1_done_cycle", dc, 1173);
        chk("t1_error", e, 0);
        chk("t1_reads", n_rd, 1104);
        chk("t1_ready", n_ready, 1);
        chk("t1_writes", n_wr, 64);
        chk("t1_first_wr", wr_log[0], 1104);
        chk("t1_last_wr", wr_log[63], 1167);
        chk("t1_busy_cycles", bcnt, dc - 1);
`ifdef LOADER_PERF_EN
        chk("t1_perf", perf_cycles, 1172);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_perf_hold", perf_cycles, bcnt);
`else
        chk("t1_perf_off", perf_cycles, 0);
`endif
        repeat (5) @(posedge clk);

        // Chain mode, two passes.
        run(2, 1, 0, 16, 1040, 1104, 64, 0, dc, da, bcnt, e);
        chk("t2_error", e, 0);
        chk("t2_ready", n_ready, 2);
        chk("t2_reads", n_rd, 2 * L);
        chk("t2_writes", n_wr, 128);
        chk("t2_bias1_addr", bias1_addr, 1104);
        chk("t2_p1_first_wr", wr_log[64], 1168);
        chk("t2_p1_last_wr", wr_log[127], 1231);
        repeat (5) @(posedge clk);

        // Illegal pass counts.
        run(0, 0, 0, 16, 1040, 1104, 64, 0, dc, da, bcnt, e);
        chk("t3a_done_cycle", dc, 2);
        chk("t3a_error", e, 1);
        chk("t3a_reads", n_rd, 0);
        repeat (3) @(posedge clk);
        run(MAXP + 1, 0, 0, 16, 1040, 1104, 64, 0, dc, da, bcnt, e);
        chk("t3b_done_cycle", dc, 2);
        chk("t3b_error", e, 1);
        chk("t3b_reads", n_rd, 0);
        repeat (3) @(posedge clk);

        // Timeout: only 10 ofmap words; error lands TMO idle cycles after the last one.
        run(1, 0, 0, 16, 1040, 1104, 10, 0, dc, da, bcnt, e);
        chk("t4_error", e, 1);
        chk("t4_done_abs", da, last_valid_cyc + TMO + 1);
        chk("t4_done_cycle", dc, 1117 + TMO + 1);
        chk("t4_writes", n_wr, 10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t4_error_sticky", error, 1);
        run(1, 0, 0, 16, 1040, 1104, 64, 0, dc, da, bcnt, e);
        chk("t4_recover_error", e, 0);
        chk("t4_recover_done", dc, 1173);
        repeat (3) @(posedge clk);

        // Surplus ofmap words are dropped and ignored once idle.
        run(1, 0, 100, 200, 300, 40000, 70, 0, dc, da, bcnt, e);
        chk("t5_writes", n_wr, 64);
        chk("t5_done_cycle", dc, 1173);
        repeat (12) @(posedge clk);

        // Start while busy ignored; start in the done cycle lost.
        fork
            run(1, 0, 0, 16, 1040, 1104, 64, 1, dc, da, bcnt, e);
            begin
                repeat (500) @(posedge clk); #1;
                start = 1'b1; num_pass = 3'd0; chain_mode = 1'b1;
                @(posedge clk); #1;
                start = 1'b0; num_pass = 3'd1; chain_mode = 1'b0;
            end
        join
        chk("t6_done_cycle", dc, 1173);
        chk("t6_error", e, 0);
        chk("t6_ready", n_ready, 1);
        repeat (4) begin
            @(negedge clk);
            chk("t6_stays_idle", busy, 0);
        end

        // acc_valid held high keeps the sequencer in QUIESCE.
        hold_valid = 1'b1;
        fork
            run(1, 0, 0, 16, 1040, 1104, 64, 0, dc, da, bcnt, e);
            begin
                repeat (20) @(posedge clk); #1;
                rel_cyc = cyc;
                hold_valid = 1'b0;
            end
        join
        chk("t7_kick_after_release", kick_cyc, rel_cyc + 1);
        chk("t7_done_cycle", dc, 1190);
        chk("t7_writes", n_wr, 64);
        repeat (5) @(posedge clk);

        // Reset in the middle of STREAM.
        num_pass = 3'd1; chain_mode = 1'b0;
        build_reads(1, 0, 0, 16, 1040, 1104);
        run_pass = 0; cur_ob = 1104; acc_words = 64;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (100) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("t8_rd_en", rd_en, 0);       chk("t8_rd_addr", rd_addr, 0);
        chk("t8_wr_en", wr_en, 0);       chk("t8_wr_addr", wr_addr, 0);
        chk("t8_wr_data", wr_data, 0);   chk("t8_acc_ready", acc_ready, 0);
        chk("t8_acc_data", acc_data, 0); chk("t8_busy", busy, 0);
        chk("t8_done", done, 0);         chk("t8_error", error, 0);
        chk("t8_perf", perf_cycles, 0);
        repeat (20) begin
            @(negedge clk);
            chk("t8_no_done", done, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
